// File: rtl/uart_frame_decoder.sv
// ============================================================================
// uart_frame_decoder : SYNC/CMD/LEN/payload/CSUM frame parser with hold/ack.
// Optional inter-byte timeout enabled by `define FRAME_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module uart_frame_decoder #(
  parameter int          MAX_LEN      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CLKS = 8680,
  localparam int         AW           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic          o_frame_valid,
  output logic [7:0]    o_cmd,
  output logic [7:0]    o_len,
  input  logic          i_frame_ack,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_csum_err,
  output logic          o_len_err,
  output logic          o_overrun,
  output logic          o_timeout_err
);

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_GET_LEN  = 3'd2,
    ST_GET_PAY  = 3'd3,
    ST_GET_CSUM = 3'd4,
    ST_HOLD     = 3'd5
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_cmd, w_cmd_nxt;
  logic [7:0]      r_len, w_len_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [7:0]      r_sum, w_sum_nxt;
  logic [7:0]      w_sum_add;
  logic            w_wr_en;
  logic            w_csum_err, w_len_err, w_overrun, w_timeout;
  logic            r_csum_err, r_len_err, r_overrun, r_timeout;
  logic            w_active;
  logic [7:0]      r_mem [MAX_LEN];
  logic [7:0]      r_rd_data;

  assign w_sum_add = r_sum + i_byte;
  assign w_active  = (r_state == ST_GET_CMD) || (r_state == ST_GET_LEN) ||
                     (r_state == ST_GET_PAY) || (r_state == ST_GET_CSUM);

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TW-1:0] r_tcnt;
  logic          w_tmo_hit;

  // Only an idle cycle can expire the timer; a byte always restarts it.
  assign w_tmo_hit = w_active && !i_byte_valid && (r_tcnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= '0;
    end else if (i_byte_valid || !w_active || w_tmo_hit) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end
`else
  logic w_tmo_hit;
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_cmd;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_sum_nxt   = r_sum;
    w_wr_en     = 1'b0;
    w_csum_err  = 1'b0;
    w_len_err   = 1'b0;
    w_overrun   = 1'b0;
    w_timeout   = 1'b0;

    if (w_tmo_hit) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_HUNT;
    end else if (i_byte_valid) begin
      case (r_state)
        ST_HUNT: begin
          if (i_byte == SYNC_BYTE) w_state_nxt = ST_GET_CMD;
        end
        ST_GET_CMD: begin
          w_cmd_nxt   = i_byte;
          w_sum_nxt   = i_byte;
          w_state_nxt = ST_GET_LEN;
        end
        ST_GET_LEN: begin
          if (i_byte > 8'(MAX_LEN)) begin
            w_len_err   = 1'b1;
            w_state_nxt = ST_HUNT;
          end else begin
            w_len_nxt   = i_byte;
            w_sum_nxt   = w_sum_add;
            w_idx_nxt   = '0;
            w_state_nxt = (i_byte == 8'h00) ? ST_GET_CSUM : ST_GET_PAY;
          end
        end
        ST_GET_PAY: begin
          w_wr_en   = 1'b1;
          w_sum_nxt = w_sum_add;
          w_idx_nxt = r_idx + AW'(1);
          if (8'(r_idx) == (r_len - 8'd1)) w_state_nxt = ST_GET_CSUM;
        end
        ST_GET_CSUM: begin
          if (w_sum_add == 8'h00) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_csum_err  = 1'b1;
            w_state_nxt = ST_HUNT;
          end
        end
        ST_HOLD: begin
          w_overrun = 1'b1;
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end

    // The ack releases the frame even when a dropped byte arrives with it.
    if (r_state == ST_HOLD && i_frame_ack) w_state_nxt = ST_HUNT;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_HUNT;
      r_cmd      <= 8'h00;
      r_len      <= 8'h00;
      r_idx      <= '0;
      r_sum      <= 8'h00;
      r_csum_err <= 1'b0;
      r_len_err  <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cmd      <= w_cmd_nxt;
      r_len      <= w_len_nxt;
      r_idx      <= w_idx_nxt;
      r_sum      <= w_sum_nxt;
      r_csum_err <= w_csum_err;
      r_len_err  <= w_len_err;
      r_overrun  <= w_overrun;
      r_timeout  <= w_timeout;
    end
  end

  // Payload buffer: contents deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_idx] <= i_byte;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_data <= 8'h00;
    else       r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_frame_valid = (r_state == ST_HOLD);
  assign o_cmd         = r_cmd;
  assign o_len         = r_len;
  assign o_rd_data     = r_rd_data;
  assign o_csum_err    = r_csum_err;
  assign o_len_err     = r_len_err;
  assign o_overrun     = r_overrun;
`ifdef FRAME_TIMEOUT_EN
  assign o_timeout_err = r_timeout;
`else
  // Timeout disabled: constant 0 (comparison on the parameter is never true).
  assign o_timeout_err = r_timeout & (TIMEOUT_CLKS < 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
// ============================================================================
// tb_uart_frame_decoder : table-driven frame vectors plus multi-cycle corner
// sequences for uart_frame_decoder.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_frame_decoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          frame_valid;
  logic [7:0]    cmd;
  logic [7:0]    len;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          csum_err, len_err, overrun, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_csum = 0, n_lenerr = 0, n_ovr = 0, n_tmo = 0;

  uart_frame_decoder #(
    .MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(8680)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_byte_valid(byte_valid), .i_byte(byte_in),
    .o_frame_valid(frame_valid), .o_cmd(cmd), .o_len(len),
    .i_frame_ack(frame_ack), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_csum_err(csum_err), .o_len_err(len_err),
    .o_overrun(overrun), .o_timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // A pulse held for two cycles is counted twice, so counts also check width.
  always @(negedge clk) begin
    if (csum_err)    n_csum++;
    if (len_err)     n_lenerr++;
    if (overrun)     n_ovr++;
    if (timeout_err) n_tmo++;
  end

  typedef struct {
    logic [63:0] bytes;
    int          n;
    logic        ev;
    logic [7:0]  ecmd;
    logic [7:0]  elen;
    int          ecsum;
    int          elenerr;
    logic [23:0] pay;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    step();
    byte_valid = 1'b1;
    byte_in    = b;
    step();
    byte_valid = 1'b0;
    byte_in    = ~b;
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    step();
    rd_addr = a;
    step();
    check(name, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic do_ack(input string name, input logic with_byte);
    step();
    frame_ack  = 1'b1;
    byte_valid = with_byte;
    byte_in    = 8'h5A;
    step();
    frame_ack  = 1'b0;
    byte_valid = 1'b0;
    check(name, {31'h0, frame_valid}, 32'h0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int c0, l0;
    c0 = n_csum;
    l0 = n_lenerr;
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) check({tag, "_prevalid"}, {31'h0, frame_valid}, 32'h0);
      send_byte(v.bytes[63-8*i -: 8]);
    end
    check({tag, "_valid"}, {31'h0, frame_valid}, {31'h0, v.ev});
    step();
    check({tag, "_csum_err"}, n_csum - c0, v.ecsum);
    check({tag, "_len_err"}, n_lenerr - l0, v.elenerr);
    if (v.ev) begin
      check({tag, "_cmd"}, {24'h0, cmd}, {24'h0, v.ecmd});
      check({tag, "_len"}, {24'h0, len}, {24'h0, v.elen});
      for (int i = 0; i < 3 && i < int'(v.elen); i++)
        read_check($sformatf("%s_rd%0d", tag, i), AW'(i), v.pay[23-8*i -: 8]);
      do_ack({tag, "_ack"}, 1'b0);
    end
  endtask

  initial begin
    int o0, t0;
    //            bytes (first byte in MSBs)   n  ev cmd    len    cs le  payload
    vecs[0] = '{64'hA501031020309C00, 7, 1'b1, 8'h01, 8'h03, 0, 0, 24'h102030};
    vecs[1] = '{64'hA50200FE00000000, 4, 1'b1, 8'h02, 8'h00, 0, 0, 24'h000000};
    vecs[2] = '{64'hA50200FF00000000, 4, 1'b0, 8'h00, 8'h00, 1, 0, 24'h000000};
    vecs[3] = '{64'hA501110000000000, 3, 1'b0, 8'h00, 8'h00, 0, 1, 24'h000000};
    vecs[4] = '{64'hA50101A559000000, 5, 1'b1, 8'h01, 8'h01, 0, 0, 24'hA50000};
    vecs[5] = '{64'h33A503027F80FC00, 7, 1'b1, 8'h03, 8'h02, 0, 0, 24'h7F8000};
    vecs[6] = '{64'hA5A501005A000000, 5, 1'b1, 8'hA5, 8'h01, 0, 0, 24'h000000};

    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'hA5; frame_ack = 1'b0; rd_addr = '0;
    repeat (3) step();
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_cmd", {24'h0, cmd}, 32'h0);
    check("rst_len", {24'h0, len}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    check("rst_pulses", {28'h0, csum_err, len_err, overrun, timeout_err}, 32'h0);
    rst = 1'b0;
    // A SYNC value on the bus without a strobe must not start a frame.
    repeat (2) step();

    for (int k = 0; k < 7; k++) run_vec($sformatf("v%0d", k), vecs[k]);

    // Maximum-length frame: LEN=16, payload 00..0F, csum 71.
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h71);
    check("max_valid", {31'h0, frame_valid}, 32'h1);
    check("max_len", {24'h0, len}, 32'h10);
    read_check("max_rd0", 4'd0, 8'h00);
    read_check("max_rd7", 4'd7, 8'h07);
    read_check("max_rd15", 4'd15, 8'h0F);
    do_ack("max_ack", 1'b0);

    // Overrun while holding, then an ack that also carries a dropped byte.
    o0 = n_ovr;
    for (int i = 0; i < 7; i++) send_byte(vecs[0].bytes[63-8*i -: 8]);
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h22);
    step();
    check("ovr_count3", n_ovr - o0, 3);
    check("ovr_valid", {31'h0, frame_valid}, 32'h1);
    check("ovr_cmd", {24'h0, cmd}, 32'h01);
    check("ovr_len", {24'h0, len}, 32'h03);
    read_check("ovr_rd0", 4'd0, 8'h10);
    read_check("ovr_rd2", 4'd2, 8'h30);
    do_ack("ovr_ack", 1'b1);
    step();
    check("ovr_count4", n_ovr - o0, 4);
    run_vec("ovr_t2", vecs[1]);

    // Long idle gap after SYNC, CMD.
    t0 = n_tmo;
    send_byte(8'hA5); send_byte(8'h01);
    repeat (9000) step();
`ifdef FRAME_TIMEOUT_EN
    check("tmo_pulse", n_tmo - t0, 1);
    for (int i = 2; i < 7; i++) send_byte(vecs[0].bytes[63-8*i -: 8]);
    check("tmo_stale_valid", {31'h0, frame_valid}, 32'h0);
    run_vec("tmo_t1", vecs[0]);
`else
    check("tmo_none", n_tmo - t0, 0);
    for (int i = 2; i < 7; i++) send_byte(vecs[0].bytes[63-8*i -: 8]);
    check("tmo_late_valid", {31'h0, frame_valid}, 32'h1);
    check("tmo_late_len", {24'h0, len}, 32'h03);
    do_ack("tmo_ack", 1'b0);
`endif

    // Reset mid-payload.
    rd_addr = 4'd0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h10);
    step();
    check("mid_rd_pre", {24'h0, rd_data}, 32'h10);
    rst = 1'b1;
    step();
    check("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
    check("mid_rst_cmd", {24'h0, cmd}, 32'h0);
    check("mid_rst_len", {24'h0, len}, 32'h0);
    check("mid_rst_rd", {24'h0, rd_data}, 32'h0);
    rst = 1'b0;
    run_vec("mid_t1", vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
